// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster geometry and sync-bundle type, imported by the
// timing generator and by renderer modules.
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int H_FP_START   = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  // Bit order {hs, vs, blank}; sync bits are active-low, blank is 1 when visible.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic logic in_range(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-tick delay line for the sync/blank bundle; depth 0 is a straight wire.
module vga_sync_delay #(
  parameter int               PIPE_DEPTH = 2,
  parameter int               WIDTH      = 3,
  parameter logic [WIDTH-1:0] INIT       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (PIPE_DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, en};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [PIPE_DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= INIT;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[PIPE_DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, raster counters, sync/blank decode
// and a delay line that lines the sync outputs up with the renderer pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DEPTH = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_en,
  output logic       vga_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_out,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [1:0] DIV_LAST  = 2'(CLK_DIV - 1);
  localparam logic [1:0] VCLK_HIGH = 2'((CLK_DIV + 1) / 2);
  // The visible area can never reach into the horizontal front porch.
  localparam int H_ACTIVE = (H_VISIBLE < H_FP_START) ? H_VISIBLE : H_FP_START;

  logic [1:0] div_cnt;
  logic [1:0] div_nxt;
  logic       x_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  sync_t      sync_raw;
  sync_t      sync_nxt;
  sync_t      sync_dly;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 2'd0 : div_cnt + 2'd1;
    x_wrap  = (DrawX == 10'(H_TOTAL - 1));
    x_nxt   = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_nxt   = DrawY;
    if (x_wrap) y_nxt = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    // Decoded from the next position so the registered flags match DrawX/DrawY.
    sync_nxt.hs    = !in_range(x_nxt, H_SYNC_START, H_SYNC_END);
    sync_nxt.vs    = !in_range(y_nxt, V_SYNC_START, V_SYNC_END);
    sync_nxt.blank = (x_nxt < 10'(H_ACTIVE)) && (y_nxt < 10'(V_VISIBLE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt     <= '0;
      pixel_en    <= 1'b0;
      vga_clk     <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      sync_raw    <= SYNC_IDLE;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      div_cnt     <= div_nxt;
      pixel_en    <= (div_cnt == DIV_LAST);
      // High for the first half of each pixel period, rising with pixel_en.
      vga_clk     <= (div_nxt < VCLK_HIGH);
      frame_start <= 1'b0;
      if (pixel_en) begin
        DrawX    <= x_nxt;
        DrawY    <= y_nxt;
        sync_raw <= sync_nxt;
        if (x_nxt == 10'd0 && y_nxt == 10'd0) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  assign blank = sync_raw.blank;

  vga_sync_delay #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .WIDTH     (3),
    .INIT      (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (Clk),
    .reset(Reset),
    .en   (pixel_en),
    .d    (sync_raw),
    .q    (sync_dly)
  );

  assign hs        = sync_dly.hs;
  assign vs        = sync_dly.vs;
  assign blank_out = sync_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a PIPE_DEPTH=2 and a PIPE_DEPTH=0 instance run in
// lockstep against a tick-level raster model with a delayed-sync expected queue.
module tb_vga_timing_gen;

  localparam int TB_DIV = 2;
  localparam int TB_PD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;

  logic       pixel_en, vga_clk, blank, hs, vs, blank_out, frame_start;
  logic [9:0] draw_x, draw_y;
  logic [7:0] frame_count;
  logic       pe0, vclk0, blank0, hs0, vs0, bo0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;

  int n_chk = 0;
  int n_fail = 0;

  logic [9:0] m_x, m_y;
  logic [7:0] m_fc;
  logic       m_first;
  logic [2:0] exp_q[$];
  longint     last_fs_cyc = 0;
  int         fs_seen = 0;

  vga_timing_gen #(.H_VISIBLE(640), .V_VISIBLE(480), .CLK_DIV(TB_DIV), .PIPE_DEPTH(TB_PD)) dut (
    .Clk(clk), .Reset(rst), .pixel_en(pixel_en), .vga_clk(vga_clk), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .hs(hs), .vs(vs), .blank_out(blank_out), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  vga_timing_gen #(.H_VISIBLE(640), .V_VISIBLE(480), .CLK_DIV(TB_DIV), .PIPE_DEPTH(0)) dut0 (
    .Clk(clk), .Reset(rst), .pixel_en(pe0), .vga_clk(vclk0), .DrawX(x0), .DrawY(y0),
    .blank(blank0), .hs(hs0), .vs(vs0), .blank_out(bo0), .frame_start(fs0),
    .frame_count(fc0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_x = '0;
    m_y = '0;
    m_fc = '0;
    m_first = 1'b1;
    exp_q.delete();
    for (int i = 0; i < TB_PD; i++) exp_q.push_back(3'b110);
  endtask

  // Backdoor raster jump on both instances; only called just after a tick.
  task automatic jump(input logic [9:0] x, input logic [9:0] y);
    dut.DrawX = x;
    dut.DrawY = y;
    dut0.DrawX = x;
    dut0.DrawY = y;
    m_x = x;
    m_y = y;
  endtask

  // Waits out the divider gap, then checks the state produced by one pixel tick.
  task automatic tick();
    int gap;
    logic [9:0] nx, ny;
    logic fs;
    logic [2:0] raw, dl;
    gap = m_first ? TB_DIV : TB_DIV - 1;
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (pixel_en !== (i == gap) || pe0 !== (i == gap) || vga_clk !== (i == gap) || vclk0 !== (i == gap)) begin
        n_fail++;
        $display("FAIL divider: cycle %0d pixel_en=%b vga_clk=%b want %b", i, pixel_en, vga_clk, (i == gap));
      end
      n_chk++;
      if (draw_x !== m_x || draw_y !== m_y || frame_start !== 1'b0 || fs0 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: x=%0d y=%0d fs=%b want x=%0d y=%0d fs=0", draw_x, draw_y, frame_start, m_x, m_y);
      end
    end
    if (m_x == 10'd799) begin
      nx = 10'd0;
      ny = (m_y == 10'd524) ? 10'd0 : m_y + 10'd1;
    end else begin
      nx = m_x + 10'd1;
      ny = m_y;
    end
    fs = (nx == 10'd0) && (ny == 10'd0);
    if (fs) m_fc = m_fc + 8'd1;
    raw[2] = !(nx >= 656 && nx <= 751);
    raw[1] = !(ny >= 490 && ny <= 491);
    raw[0] = (nx < 640) && (ny < 480);
    exp_q.push_back(raw);
    dl = exp_q.pop_front();
    @(posedge clk); #1;
    n_chk++;
    if (draw_x !== nx || draw_y !== ny) begin
      n_fail++;
      $display("FAIL position: got x=%0d y=%0d want x=%0d y=%0d", draw_x, draw_y, nx, ny);
    end
    n_chk++;
    if (blank !== raw[0]) begin
      n_fail++;
      $display("FAIL blank: at x=%0d y=%0d got %b want %b", nx, ny, blank, raw[0]);
    end
    n_chk++;
    if ({hs, vs, blank_out} !== dl) begin
      n_fail++;
      $display("FAIL delayed_sync: at x=%0d y=%0d got %b want %b", nx, ny, {hs, vs, blank_out}, dl);
    end
    n_chk++;
    if (frame_start !== fs || frame_count !== m_fc) begin
      n_fail++;
      $display("FAIL frame: fs=%b fc=%0d want fs=%b fc=%0d", frame_start, frame_count, fs, m_fc);
    end
    n_chk++;
    if (pixel_en !== (TB_DIV == 1)) begin
      n_fail++;
      $display("FAIL pixel_en_after_tick: got %b want %b", pixel_en, (TB_DIV == 1));
    end
    n_chk++;
    if ({x0, y0, fs0, fc0} !== {nx, ny, fs, m_fc} || {hs0, vs0, bo0} !== raw || blank0 !== raw[0]) begin
      n_fail++;
      $display("FAIL depth0: x=%0d y=%0d sync=%b want x=%0d y=%0d sync=%b", x0, y0, {hs0, vs0, bo0}, nx, ny, raw);
    end
    if (fs) begin
      last_fs_cyc = cyc;
      fs_seen++;
    end
    m_x = nx;
    m_y = ny;
    m_first = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({pixel_en, vga_clk, blank, frame_start} !== 4'b0000 || {pe0, vclk0, blank0, fs0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b/%b want 0000", {pixel_en, vga_clk, blank, frame_start}, {pe0, vclk0, blank0, fs0});
    end
    n_chk++;
    if (draw_x !== 10'd0 || draw_y !== 10'd0 || frame_count !== 8'd0 || x0 !== 10'd0 || y0 !== 10'd0 || fc0 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts: x=%0d y=%0d fc=%0d want 0 0 0", draw_x, draw_y, frame_count);
    end
    n_chk++;
    if ({hs, vs, blank_out} !== 3'b110 || {hs0, vs0, bo0} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_sync: got %b/%b want 110", {hs, vs, blank_out}, {hs0, vs0, bo0});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_frame_wrap();
    jump(10'd797, 10'd524);
    tick();
    tick();
    n_chk++;
    if (draw_x !== 10'd799 || draw_y !== 10'd524) begin
      n_fail++;
      $display("FAIL last_pixel: got x=%0d y=%0d want 799 524", draw_x, draw_y);
    end
    tick();
    n_chk++;
    if (draw_x !== 10'd0 || draw_y !== 10'd0 || frame_start !== 1'b1 || frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL frame_wrap: x=%0d y=%0d fs=%b fc=%0d want 0 0 1 1", draw_x, draw_y, frame_start, frame_count);
    end
  endtask

  // Starts at (0,0) of a frame and observes all of line 0.
  task automatic test_line0();
    int hs_low, hs_first, blank_hi, fall_b, fall_bo, fall_bo0;
    logic pb, pbo, pbo0;
    hs_low = 0;
    hs_first = -1;
    blank_hi = 0;
    fall_b = -1;
    fall_bo = -1;
    fall_bo0 = -1;
    pb = blank;
    pbo = blank_out;
    pbo0 = bo0;
    for (int k = 0; k < 800; k++) begin
      if (k > 0) tick();
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (blank === 1'b1) blank_hi++;
      if (pb === 1'b1 && blank === 1'b0 && fall_b < 0) fall_b = k;
      if (pbo === 1'b1 && blank_out === 1'b0 && fall_bo < 0) fall_bo = k;
      if (pbo0 === 1'b1 && bo0 === 1'b0 && fall_bo0 < 0) fall_bo0 = k;
      pb = blank;
      pbo = blank_out;
      pbo0 = bo0;
    end
    n_chk++;
    if (hs_low != 96 || hs_first != 656 + TB_PD) begin
      n_fail++;
      $display("FAIL hsync_width: low=%0d first=%0d want 96 %0d", hs_low, hs_first, 656 + TB_PD);
    end
    n_chk++;
    if (blank_hi != 640) begin
      n_fail++;
      $display("FAIL visible_width: got %0d want 640", blank_hi);
    end
    n_chk++;
    if (fall_b != 640 || fall_bo - fall_b != TB_PD || fall_bo0 - fall_b != 0) begin
      n_fail++;
      $display("FAIL blank_lag: blank=%0d d2=%0d d0=%0d want 640 lag %0d and 0", fall_b, fall_bo, fall_bo0, TB_PD);
    end
    tick();
  endtask

  // Two frames; most of each frame's lines are skipped by a backdoor jump and
  // their cycle cost is added back arithmetically.
  task automatic test_free_run();
    longint c0, skipped;
    logic [7:0] f0;
    int s0;
    jump(10'd795, 10'd524);
    repeat (5) tick();
    c0 = last_fs_cyc;
    f0 = m_fc;
    s0 = fs_seen;
    skipped = 0;
    repeat (2) begin
      repeat (800) tick();
      jump(10'd0, 10'd522);
      skipped += 521 * 800 * TB_DIV;
      repeat (2400) tick();
    end
    n_chk++;
    if ((last_fs_cyc - c0) + skipped != 64'd1680000) begin
      n_fail++;
      $display("FAIL two_frame_period: got %0d want 1680000", (last_fs_cyc - c0) + skipped);
    end
    n_chk++;
    if (fs_seen - s0 != 2 || frame_count !== f0 + 8'd2) begin
      n_fail++;
      $display("FAIL two_frame_count: pulses=%0d fc=%0d want 2 %0d", fs_seen - s0, frame_count, f0 + 8'd2);
    end
  endtask

  task automatic test_midframe_reset();
    jump(10'd295, 10'd200);
    repeat (5) tick();
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (draw_x !== 10'd0 || draw_y !== 10'd0 || frame_count !== 8'd0 || x0 !== 10'd0 || fc0 !== 8'd0) begin
      n_fail++;
      $display("FAIL midframe_reset_counts: x=%0d y=%0d fc=%0d want 0 0 0", draw_x, draw_y, frame_count);
    end
    n_chk++;
    if ({hs, vs, blank_out, pixel_en, frame_start} !== 5'b11000 || {hs0, vs0, bo0} !== 3'b110) begin
      n_fail++;
      $display("FAIL midframe_reset_sync: got %b want 11000", {hs, vs, blank_out, pixel_en, frame_start});
    end
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
  endtask

  task automatic test_fc_wrap();
    dut.frame_count = 8'd255;
    dut0.frame_count = 8'd255;
    m_fc = 8'd255;
    jump(10'd798, 10'd524);
    tick();
    tick();
    n_chk++;
    if (frame_count !== 8'd0 || fc0 !== 8'd0 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_count_wrap: fc=%0d fs=%b want 0 1", frame_count, frame_start);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_wrap();
    test_line0();
    test_free_run();
    test_midframe_reset();
    test_fc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
